// File: rtl/messbauer_seq_pkg.sv
// Shared types and default widths for the Mossbauer channel sequencer.
// Holds the sequencer state enum, default parameter widths and the sweep
// counter width.
package messbauer_seq_pkg;

  localparam int unsigned CH_W_DEF    = 12;
  localparam int unsigned DWELL_W_DEF = 16;
  localparam int unsigned DEAD_W_DEF  = 8;
  localparam int unsigned SWEEP_W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/det_edge_sync.sv
// Detector input conditioning: 2-FF synchronizer followed by a rising-edge
// detector.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset
//   async_in - asynchronous detector level
//   rise     - combinational one-cycle flag, synchronized rising edge seen
module det_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/messbauer_channel_sequencer.sv
// Velocity-channel sequencer feeding the Mossbauer accumulator: generates
// start/chanel sweep timing from a programmable channel count and dwell, and
// turns the asynchronous detector input into count pulses that never land on
// a channel boundary.
// Ports:
//   clk, rst (sync, active-low)
//   enable               - run request (level)
//   n_channels, dwell    - sweep shape, shadowed on IDLE->RUN
//   dead_time            - detector dead time in clocks
//   det_in               - asynchronous detector pulse
//   start, chanel, count - one-cycle pulses
//   channel, running, sweeps - status
// Build option: define MESSBAUER_SEQ_DEADTIME_EN to enable detector dead time;
// otherwise dead_time is ignored and no dead-time counter is built.
module messbauer_channel_sequencer
  import messbauer_seq_pkg::*;
#(
  parameter int unsigned CH_W    = CH_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned DEAD_W  = DEAD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CH_W-1:0]    n_channels,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [DEAD_W-1:0]  dead_time,
  input  logic               det_in,
  output logic               start,
  output logic               chanel,
  output logic               count,
  output logic [CH_W-1:0]    channel,
  output logic               running,
  output logic [SWEEP_W-1:0] sweeps
);

  state_t               state_q, state_d;
  logic                 first_q, first_d;
  logic [CH_W-1:0]      sh_n_q, sh_n_d;
  logic [DWELL_W-1:0]   sh_dwell_q, sh_dwell_d;
  logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
  logic [DWELL_W-1:0]   reload;
  logic [CH_W-1:0]      last_ch;
  logic [CH_W-1:0]      channel_d;
  logic [SWEEP_W-1:0]   sweeps_d;
  logic                 start_d, chanel_d, running_d;
  logic                 rise, acc;
  logic                 pending_q, pending_d;
  logic                 count_d;

  // Dwell 0 behaves as 1; n_channels 0 wraps to all-ones, i.e. 2^CH_W channels.
  assign reload  = (sh_dwell_q == '0) ? '0 : sh_dwell_q - DWELL_W'(1);
  assign last_ch = sh_n_q - CH_W'(1);

  det_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (det_in),
    .rise     (rise)
  );

  // Sequencer next state; first_q marks the opening cycle of a run.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    sh_n_d     = sh_n_q;
    sh_dwell_d = sh_dwell_q;
    dcnt_d     = dcnt_q;
    channel_d  = channel;
    sweeps_d   = sweeps;
    start_d    = 1'b0;
    chanel_d   = 1'b0;
    running_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = RUN;
          first_d    = 1'b1;
          sh_n_d     = n_channels;
          sh_dwell_d = dwell;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          first_d = 1'b0;
        end else begin
          running_d = 1'b1;
          if (first_q) begin
            first_d   = 1'b0;
            start_d   = 1'b1;
            channel_d = '0;
            dcnt_d    = reload;
          end else if (dcnt_q == '0) begin
            dcnt_d = reload;
            if (channel == last_ch) begin
              start_d   = 1'b1;
              channel_d = '0;
              sweeps_d  = sweeps + SWEEP_W'(1);
            end else begin
              chanel_d  = 1'b1;
              channel_d = channel + CH_W'(1);
            end
          end else begin
            dcnt_d = dcnt_q - DWELL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MESSBAUER_SEQ_DEADTIME_EN
  logic [DEAD_W-1:0] dead_q, dead_d;

  // Dead time is armed on acceptance, not on emission of count.
  always_comb begin
    acc    = rise & (dead_q == '0);
    dead_d = dead_q;
    if (acc) begin
      dead_d = dead_time;
    end else if (dead_q != '0) begin
      dead_d = dead_q - DEAD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dead_q <= '0;
    end else begin
      dead_q <= dead_d;
    end
  end
`else
  logic unused_dead_time;

  assign acc              = rise;
  assign unused_dead_time = ^dead_time;
`endif

  // Edges landing on a boundary slip one cycle; spacing of synchronized
  // edges (>= 2 cycles) guarantees the pending flag is free again.
  always_comb begin
    count_d   = (acc & ~(start_d | chanel_d)) | pending_q;
    pending_d = acc & (start_d | chanel_d);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      sh_n_q     <= '0;
      sh_dwell_q <= '0;
      dcnt_q     <= '0;
      channel    <= '0;
      sweeps     <= '0;
      start      <= 1'b0;
      chanel     <= 1'b0;
      running    <= 1'b0;
      pending_q  <= 1'b0;
      count      <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      sh_n_q     <= sh_n_d;
      sh_dwell_q <= sh_dwell_d;
      dcnt_q     <= dcnt_d;
      channel    <= channel_d;
      sweeps     <= sweeps_d;
      start      <= start_d;
      chanel     <= chanel_d;
      running    <= running_d;
      pending_q  <= pending_d;
      count      <= count_d;
    end
  end

endmodule

// File: tb/tb_messbauer_channel_sequencer.sv
// Self-checking bench for messbauer_channel_sequencer: directed scenarios with
// literal expectations plus randomized traffic against a time-based model.
module tb_messbauer_channel_sequencer;

  localparam int unsigned CH_W    = 12;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned DEAD_W  = 8;

  logic               clk;
  logic               rst;
  logic               enable;
  logic [CH_W-1:0]    n_channels;
  logic [DWELL_W-1:0] dwell;
  logic [DEAD_W-1:0]  dead_time;
  logic               det_in;
  logic               start, chanel, count, running;
  logic [CH_W-1:0]    channel;
  logic [15:0]        sweeps;

  int errors = 0;
  int checks = 0;

  messbauer_channel_sequencer #(
    .CH_W(CH_W), .DWELL_W(DWELL_W), .DEAD_W(DEAD_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .n_channels(n_channels),
    .dwell(dwell), .dead_time(dead_time), .det_in(det_in),
    .start(start), .chanel(chanel), .count(count), .channel(channel),
    .running(running), .sweeps(sweeps)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep position is derived from elapsed cycles since the
  // opening start; detector from a history of sampled det_in values.
  int     mode;          // 0 idle, 1 run requested, 2 running
  longint t;
  longint sh_n, sh_d;
  longint base_sw;
  longint edge_no;
  longint block_until;
  bit     h[3];
  bit     pend, cand, acc, model_valid;
  bit     e_start, e_chanel, e_count, e_running;
  int     e_channel, e_sweeps;

  initial begin
    model_valid = 0;
    edge_no = 0;
    forever begin
      @(posedge clk);
      edge_no++;
      if (!rst) begin
        mode = 0; t = 0; base_sw = 0; sh_n = 1; sh_d = 1;
        e_start = 0; e_chanel = 0; e_count = 0; e_running = 0;
        e_channel = 0; e_sweeps = 0;
        h[0] = 0; h[1] = 0; h[2] = 0; pend = 0;
        block_until = edge_no;
        model_valid = 1;
      end else begin
        e_start = 0; e_chanel = 0; e_running = 0;
        if (mode == 0) begin
          if (enable) begin
            mode = 1;
            sh_n = (n_channels == 0) ? (longint'(1) << CH_W) : longint'(n_channels);
            sh_d = (dwell == 0) ? 1 : longint'(dwell);
          end
        end else if (!enable) begin
          mode = 0;
        end else begin
          if (mode == 1) begin
            mode = 2; t = 0; base_sw = e_sweeps;
          end else begin
            t++;
          end
          e_running = 1;
          e_channel = int'((t / sh_d) % sh_n);
          e_start   = (t % (sh_n * sh_d)) == 0;
          e_chanel  = !e_start && ((t % sh_d) == 0);
          e_sweeps  = int'((base_sw + t / (sh_n * sh_d)) % 65536);
        end
        cand = h[1] && !h[2];
`ifdef MESSBAUER_SEQ_DEADTIME_EN
        acc = cand && (edge_no > block_until);
        if (acc) block_until = edge_no + longint'(dead_time);
`else
        acc = cand;
`endif
        e_count = (acc && !(e_start || e_chanel)) || pend;
        pend    = acc && (e_start || e_chanel);
        h[2] = h[1]; h[1] = h[0]; h[0] = det_in;
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("start",   start,   e_start);
        check("chanel",  chanel,  e_chanel);
        check("count",   count,   e_count);
        check("channel", channel, e_channel);
        check("running", running, e_running);
        check("sweeps",  sweeps,  e_sweeps);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic det_pair(input int gap, output int got);
    got = 0;
    for (int i = 0; i <= gap + 8; i++) begin
      det_in = (i == 0 || i == gap);
      step(1);
      got += int'(count);
    end
    det_in = 1'b0;
  endtask

  task automatic gap_check(input string nm, input int cycles, input int want);
    int last;
    last = -1;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (start || chanel) begin
        if (last >= 0) check(nm, i - last, want);
        last = i;
      end
    end
  endtask

  bit st[14], chn[14], cn[14];
  int got, found, pulses, overlap, total;

  initial begin
    rst = 1'b0; enable = 1'b0; n_channels = '0; dwell = '0;
    dead_time = '0; det_in = 1'b0;
    step(3);
    check("rst_start", start, 0);
    check("rst_chanel", chanel, 0);
    check("rst_count", count, 0);
    check("rst_channel", channel, 0);
    check("rst_running", running, 0);
    check("rst_sweeps", sweeps, 0);
    rst = 1'b1;
    step(2);

    // Dead time in IDLE.
    dead_time = 8'd5;
    det_pair(3, got);
`ifdef MESSBAUER_SEQ_DEADTIME_EN
    check("dead_gap3", got, 1);
`else
    check("dead_gap3", got, 2);
`endif
    step(10);
    det_pair(7, got);
    check("dead_gap7", got, 2);
    step(10);

    // Basic sweep with a detector edge landing on the first chanel.
    dead_time = 8'd0; n_channels = 12'd3; dwell = 16'd4; enable = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step(1);
      st[k] = start; chn[k] = chanel; cn[k] = count;
      if (k == 13) check("sweep1_sweeps", sweeps, 1);
      if (k == 9) check("sweep1_ch2", channel, 2);
      det_in = (k == 2);
    end
    det_in = 1'b0;
    check("sweep1_start_t1", st[1], 1);
    check("sweep1_chanel_t5", chn[5], 1);
    check("sweep1_chanel_t9", chn[9], 1);
    check("sweep1_start_t13", st[13], 1);
    total = 0; overlap = 0; pulses = 0;
    for (int k = 0; k < 14; k++) begin
      total += int'(cn[k]);
      overlap += int'(cn[k] && (chn[k] || st[k]));
      pulses += int'(st[k]) + int'(chn[k]);
    end
    check("sweep1_pulses", pulses, 4);
    check("coin_deferred_t5", cn[5], 0);
    check("coin_count_t6", cn[6], 1);
    check("coin_total", total, 1);
    check("coin_overlap", overlap, 0);
    enable = 1'b0;
    step(4);

    // Shadowing: dwell change mid-run takes effect only after re-enable.
    n_channels = 12'd3; dwell = 16'd4; enable = 1'b1;
    step(2);
    dwell = 16'd8;
    gap_check("shadow_gap4", 30, 4);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    gap_check("shadow_gap8", 40, 8);
    enable = 1'b0;
    step(4);

    // Enable drop at channel 2, re-enable, then reset mid-run.
    n_channels = 12'd5; dwell = 16'd3; enable = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step(1);
      if (channel == 12'd2 && chanel) found = 1;
    end
    check("reach_ch2", found, 1);
    enable = 1'b0;
    step(1);
    check("drop_running", running, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      pulses += int'(start | chanel);
    end
    check("drop_pulses", pulses, 0);
    check("drop_hold_ch", channel, 2);
    enable = 1'b1;
    step(2);
    check("reen_start", start, 1);
    check("reen_channel", channel, 0);
    check("reen_running", running, 1);
    step(3);
    rst = 1'b0;
    step(1);
    check("mrst_start", start, 0);
    check("mrst_chanel", chanel, 0);
    check("mrst_channel", channel, 0);
    check("mrst_running", running, 0);
    check("mrst_sweeps", sweeps, 0);
    rst = 1'b1; enable = 1'b0;
    step(3);

    // Full-range sweep: n_channels=0, dwell=0.
    n_channels = 12'd0; dwell = 16'd0; enable = 1'b1;
    step(2);
    check("full_start0", start, 1);
    check("full_ch0", channel, 0);
    step(4095);
    check("full_ch4095", channel, 4095);
    check("full_chanel", chanel, 1);
    step(1);
    check("full_wrap_start", start, 1);
    check("full_wrap_ch", channel, 0);
    check("full_sweeps", sweeps, 1);
    enable = 1'b0;
    step(3);

    // Randomized traffic, checked by the model every cycle.
    enable = 1'b1; n_channels = 12'd4; dwell = 16'd2; dead_time = 8'd3;
    for (int c = 0; c < 5000; c++) begin
      det_in = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) begin
        n_channels = CH_W'($urandom_range(0, 6));
        dwell      = DWELL_W'($urandom_range(0, 5));
        dead_time  = DEAD_W'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 499) != 0);
      step(1);
    end
    rst = 1'b1; enable = 1'b0; det_in = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
